// File: rtl/fifo_sync_pkg.sv
// Shared definitions for fifo_sync and its read-side drain engine.
// Holds the default word width and the skid-buffer occupancy encoding.
package fifo_sync_pkg;

  localparam int FIFO_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/fifo_sync_reader_if.sv
// Bundles the FIFO read port and the downstream stream of fifo_sync_reader.
// master = the reader, slave = the FIFO plus downstream consumer side.
interface fifo_sync_reader_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  fifo_cs;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  fifo_empty;

  // Stream handshake: a word transfers at a rising edge where m_valid & m_ready;
  // once m_valid is high, m_valid and m_data hold until that transfer happens.
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    output fifo_cs, fifo_rd_en, m_valid, m_data,
    input  fifo_data_out, fifo_empty, m_ready
  );

  modport slave (
    input  fifo_cs, fifo_rd_en, m_valid, m_data,
    output fifo_data_out, fifo_empty, m_ready
  );

endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer: head register drives the output, tail holds the
// second word while the consumer stalls. Occupancy FSM is exposed on occ.
module fifo_skid_buf
  import fifo_sync_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output occ_t                  occ
);

  logic [DATA_WIDTH-1:0] tail;
  logic                  pop;

  assign pop      = out_valid & out_ready;
  assign in_ready = (occ != OCC_TWO) | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ       <= OCC_EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      tail      <= '0;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (in_valid) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            occ       <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          // With a simultaneous pop the new word replaces the departing head.
          if (in_valid && pop) begin
            out_data <= in_data;
          end else if (in_valid) begin
            tail <= in_data;
            occ  <= OCC_TWO;
          end else if (pop) begin
            out_valid <= 1'b0;
            occ       <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (pop) begin
            out_data <= tail;
            if (in_valid) tail <= in_data;
            else          occ  <= OCC_ONE;
          end
        end
        default: begin
          occ       <= OCC_EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_sync_reader.sv
// Drain engine for fifo_sync: issues credit-limited reads and streams words out.
// Define FIFO_READER_CNT_EN to add the rd_count delivered-word counter.
module fifo_sync_reader
  import fifo_sync_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
`ifdef FIFO_READER_CNT_EN
  ,
  parameter int CNT_WIDTH  = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  drain_en,
  fifo_sync_reader_if.master    bus,
`ifdef FIFO_READER_CNT_EN
  output logic [CNT_WIDTH-1:0]  rd_count,
`endif
  output occ_t                  dbg_occ,
  output logic                  dbg_inflight
);

  logic       inflight;
  logic       pop;
  logic       skid_ready;
  logic [2:0] committed;

  assign pop       = bus.m_valid & bus.m_ready;
  assign committed = {1'b0, dbg_occ} + {2'b0, inflight};

  // A read is only issued if its word is guaranteed a skid slot when it lands.
  assign bus.fifo_rd_en = rst_n & drain_en & ~bus.fifo_empty
                        & (committed < (3'd2 + {2'b0, pop}));
  assign bus.fifo_cs    = bus.fifo_rd_en;
  assign dbg_inflight   = inflight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= bus.fifo_rd_en;
  end

  fifo_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inflight),
    .in_ready  (skid_ready),
    .in_data   (bus.fifo_data_out),
    .out_valid (bus.m_valid),
    .out_ready (bus.m_ready),
    .out_data  (bus.m_data),
    .occ       (dbg_occ)
  );

  assert property (@(posedge clk) disable iff (!rst_n) !(inflight && !skid_ready));

`ifdef FIFO_READER_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   rd_count <= '0;
    else if (pop) rd_count <= rd_count + CNT_WIDTH'(1);
  end
`endif

endmodule
